// File: rtl/iobus_checker.sv
// Checks CPU IO writes against per-channel expected-value FIFOs; status is registered one edge after a sampled write.
// exp_ready backpressures loads per channel (full FIFO admits a push only with a same-cycle pop); IOCHK_MASK_EN adds per-entry compare masks.
module iobus_checker #(
    parameter int          NUM_CH         = 2,
    parameter int          DEPTH          = 16,
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF0000,
    parameter int          ADDR_STRIDE    = 4,
    parameter int          TIMEOUT_CYCLES = 2000,
    localparam int         CHW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     iobus_out,
    input  logic [31:0]     iobus_addr,
    input  logic            iobus_wr,
    input  logic            exp_valid,
    output logic            exp_ready,
    input  logic [CHW-1:0]  exp_chan,
    input  logic [31:0]     exp_data,
`ifdef IOCHK_MASK_EN
    input  logic [31:0]     exp_mask,
`endif
    input  logic            exp_last,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [15:0]     pass_count,
    output logic [1:0]      err_chan,
    output logic [31:0]     err_obs,
    output logic [31:0]     err_exp
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int NCH2 = 1 << CHW;
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TOUT} state_t;
    state_t state, state_n;

    logic [31:0]     fifo_dat [NUM_CH][DEPTH];
`ifdef IOCHK_MASK_EN
    logic [31:0]     fifo_msk [NUM_CH][DEPTH];
`endif
    logic [PW-1:0]   wr_ptr [NUM_CH];
    logic [PW-1:0]   rd_ptr [NUM_CH];
    // Padded to a power of two: unused channel slots read as empty and full.
    logic [NCH2-1:0] empty, full, push, pop;
    logic            last_seen, all_empty, active;
    logic [CW-1:0]   cyc_cnt, cyc_nxt;
    logic            hit, run_hit, match, err_now;
    logic [CHW-1:0]  hit_ch;
    logic [31:0]     head_dat, head_msk;

    always_comb begin
        empty = '1;
        full  = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            empty[k] = (wr_ptr[k] == rd_ptr[k]);
            full[k]  = (wr_ptr[k] == (rd_ptr[k] ^ PW'(DEPTH)));
        end
    end
    assign all_empty = &empty;

    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (iobus_wr && iobus_addr == BASE_ADDR + 32'(k * ADDR_STRIDE)) begin
                hit    = 1'b1;
                hit_ch = CHW'(k);
            end
        end
    end

    assign head_dat = fifo_dat[hit_ch][rd_ptr[hit_ch][AW-1:0]];
`ifdef IOCHK_MASK_EN
    assign head_msk = fifo_msk[hit_ch][rd_ptr[hit_ch][AW-1:0]];
`else
    assign head_msk = '1;
`endif
    assign match   = ((iobus_out ^ head_dat) & head_msk) == 32'd0;
    assign run_hit = hit && (state == RUN);
    assign err_now = run_hit && (empty[hit_ch] || !match);

    always_comb begin
        pop         = '0;
        pop[hit_ch] = run_hit && !empty[hit_ch] && match;
    end

    assign active    = (state == IDLE) || (state == RUN);
    assign exp_ready = active && (!full[exp_chan] || pop[exp_chan]);

    always_comb begin
        push           = '0;
        push[exp_chan] = exp_valid && exp_ready;
    end

    assign cyc_nxt = cyc_cnt + CW'(1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (err_now)
                    state_n = FAIL;
                else if (last_seen && all_empty)
                    state_n = PASS;
                else if (cyc_nxt == CW'(TIMEOUT_CYCLES))
                    state_n = TOUT;
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_seen  <= 1'b0;
            cyc_cnt    <= '0;
            pass_count <= '0;
            err_chan   <= '0;
            err_obs    <= '0;
            err_exp    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            state <= state_n;
            if (exp_valid && exp_ready && exp_last)
                last_seen <= 1'b1;
            if (state == RUN)
                cyc_cnt <= cyc_nxt;
            if ((|pop) && pass_count != 16'hFFFF)
                pass_count <= pass_count + 16'd1;
            if (err_now) begin
                err_chan <= 2'(hit_ch);
                err_obs  <= iobus_out;
                err_exp  <= empty[hit_ch] ? 32'd0 : head_dat;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
            end
        end
    end

    // Storage needs no reset: pointers alone define occupancy.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k]) begin
                fifo_dat[k][wr_ptr[k][AW-1:0]] <= exp_data;
`ifdef IOCHK_MASK_EN
                fifo_msk[k][wr_ptr[k][AW-1:0]] <= exp_mask;
`endif
            end
        end
    end

    assign pass    = (state == PASS);
    assign fail    = (state == FAIL);
    assign timeout = (state == TOUT);
    assign done    = pass | fail | timeout;
endmodule

// File: tb/tb_iobus_checker.sv
// Directed bench for iobus_checker (2 channels, depth 2, 50-cycle timeout).
module tb_iobus_checker;
    logic        clk = 1'b0;
    logic        rst, start, iobus_wr, exp_valid, exp_last;
    logic [31:0] iobus_out, iobus_addr, exp_data, exp_mask;
    logic        exp_chan, exp_ready;
    logic        done, pass, fail, timeout;
    logic [15:0] pass_count;
    logic [1:0]  err_chan;
    logic [31:0] err_obs, err_exp;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iobus_checker #(
        .NUM_CH(2), .DEPTH(2), .BASE_ADDR(32'hFFFF0000),
        .ADDR_STRIDE(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .iobus_out(iobus_out), .iobus_addr(iobus_addr), .iobus_wr(iobus_wr),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_chan(exp_chan),
        .exp_data(exp_data),
`ifdef IOCHK_MASK_EN
        .exp_mask(exp_mask),
`endif
        .exp_last(exp_last),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .pass_count(pass_count), .err_chan(err_chan),
        .err_obs(err_obs), .err_exp(err_exp)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic ch, input logic [31:0] dat, input logic last);
        exp_valid = 1'b1;
        exp_chan  = ch;
        exp_data  = dat;
        exp_last  = last;
        tick();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] dat);
        iobus_wr   = 1'b1;
        iobus_addr = addr;
        iobus_out  = dat;
        tick();
        iobus_wr   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; iobus_wr = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
        iobus_out = '0; iobus_addr = '0; exp_data = '0; exp_mask = '1; exp_chan = 1'b0;
        #2;

        // Reset state
        do_reset();
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_fail", fail, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_pass_count", pass_count, 0);
        check_eq("rst_err_chan", err_chan, 0);
        check_eq("rst_err_obs", err_obs, 0);
        check_eq("rst_err_exp", err_exp, 0);
        check_eq("rst_exp_ready", exp_ready, 1);

        // Three matching writes on channel 0, last value loaded during RUN
        load(0, 32'd10, 0);
        load(0, 32'd30, 0);
        pulse_start();
        wr(32'hFFFF0000, 32'd10);
        load(0, 32'd83886080, 1);
        wr(32'hFFFF0000, 32'd30);
        wr(32'hFFFF0000, 32'd83886080);
        tick();
        check_eq("seq_pass", pass, 1);
        check_eq("seq_done", done, 1);
        check_eq("seq_fail", fail, 0);
        check_eq("seq_pass_count", pass_count, 3);
        check_eq("seq_ready_terminal", exp_ready, 0);
        pulse_start();
        check_eq("seq_start_ignored", pass, 1);

        // Single mismatch; an IDLE write must be ignored first
        do_reset();
        load(0, 32'd10, 1);
        wr(32'hFFFF0000, 32'd11);
        check_eq("idle_wr_ignored", fail, 0);
        pulse_start();
        wr(32'hFFFF0000, 32'd11);
        check_eq("mm_fail", fail, 1);
        check_eq("mm_pass", pass, 0);
        check_eq("mm_err_chan", err_chan, 0);
        check_eq("mm_err_obs", err_obs, 11);
        check_eq("mm_err_exp", err_exp, 10);
        check_eq("mm_pass_count", pass_count, 0);

        // Mismatch on channel 1; later writes do not overwrite the capture
        do_reset();
        load(1, 32'd5, 1);
        pulse_start();
        wr(32'hFFFF0004, 32'd7);
        check_eq("ch1_fail", fail, 1);
        check_eq("ch1_err_chan", err_chan, 1);
        check_eq("ch1_err_obs", err_obs, 7);
        check_eq("ch1_err_exp", err_exp, 5);
        wr(32'hFFFF0000, 32'd5);
        check_eq("ch1_err_held", err_obs, 7);

        // Unmapped address ignored, then a hit on an empty FIFO
        do_reset();
        load(1, 32'd5, 1);
        pulse_start();
        wr(32'hFFFF0008, 32'd1);
        check_eq("unmapped_ignored", fail, 0);
        wr(32'hFFFF0000, 32'd3);
        check_eq("empty_fail", fail, 1);
        check_eq("empty_err_chan", err_chan, 0);
        check_eq("empty_err_obs", err_obs, 3);
        check_eq("empty_err_exp", err_exp, 0);

        // Timeout exactly 50 cycles after start
        do_reset();
        load(0, 32'd1, 1);
        pulse_start();
        repeat (49) tick();
        check_eq("tout_before", timeout, 0);
        tick();
        check_eq("tout_at", timeout, 1);
        check_eq("tout_pass", pass, 0);
        check_eq("tout_fail", fail, 0);
        check_eq("tout_done", done, 1);

        // Push-through on a full FIFO, then reset mid-RUN
        do_reset();
        load(0, 32'hA, 0);
        load(0, 32'hB, 0);
        exp_valid = 1'b1; exp_chan = 0; exp_data = 32'hC;
        #1;
        check_eq("full_not_ready", exp_ready, 0);
        exp_valid = 1'b0;
        pulse_start();
        exp_valid = 1'b1; exp_chan = 0; exp_data = 32'hC;
        iobus_wr = 1'b1; iobus_addr = 32'hFFFF0000; iobus_out = 32'hA;
        #1;
        check_eq("pushthru_ready", exp_ready, 1);
        tick();
        exp_valid = 1'b0; iobus_wr = 1'b0;
        wr(32'hFFFF0000, 32'hB);
        wr(32'hFFFF0000, 32'hC);
        check_eq("pushthru_count", pass_count, 3);
        check_eq("pushthru_fail", fail, 0);
        load(0, 32'hD, 0);
        do_reset();
        check_eq("midrst_pass_count", pass_count, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_ready", exp_ready, 1);
        load(0, 32'd99, 1);
        pulse_start();
        wr(32'hFFFF0000, 32'd99);
        tick();
        check_eq("midrst_discard_pass", pass, 1);
        check_eq("midrst_discard_count", pass_count, 1);

        // Masked compare when enabled, full equality otherwise
        do_reset();
`ifdef IOCHK_MASK_EN
        exp_mask = 32'h000000FF;
        load(0, 32'hFFFFFFE2, 1);
        exp_mask = '1;
        pulse_start();
        wr(32'hFFFF0000, 32'h123456E2);
        check_eq("mask_count", pass_count, 1);
        check_eq("mask_fail", fail, 0);
`else
        load(0, 32'hFFFFFFE2, 1);
        pulse_start();
        wr(32'hFFFF0000, 32'h123456E2);
        check_eq("nomask_fail", fail, 1);
        check_eq("nomask_err_obs", err_obs, 32'h123456E2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/iobus_checker.md
IOBUS_CHECKER -- requirements
Module: iobus_checker

Interface
REQ-001 Parameters, one per line:
- NUM_CH, 2: number of checked IO channels, 1..4.
- DEPTH, 16: expected-value FIFO depth per channel, power of 2, 2..64.
- BASE_ADDR, 32'hFFFF0000: IO address of channel 0.
- ADDR_STRIDE, 4: byte offset between consecutive channel addresses.
- TIMEOUT_CYCLES, 2000: maximum RUN-state cycles, 1..2^20.
REQ-002 Ports, one per line: name direction width meaning.
- clk in 1: sole clock; all logic on its rising edge.
- rst in 1: synchronous, active-high reset.
- start in 1: one-cycle pulse that moves IDLE to RUN.
- iobus_out in 32: CPU IO write data.
- iobus_addr in 32: CPU IO address.
- iobus_wr in 1: CPU IO write strobe.
- exp_valid in 1: expected-value load request.
- exp_ready out 1: high when the FIFO of exp_chan is not full and the state is IDLE or RUN.
- exp_chan in $clog2(NUM_CH) (min 1): target channel of the load.
- exp_data in 32: expected value.
- exp_last in 1: marks the final expected value of the test.
- done out 1: test has ended (pass, fail or timeout).
- pass out 1: test ended with every expected value matched.
- fail out 1: test ended on a mismatch or an unexpected write.
- timeout out 1: test ended on timeout.
- pass_count out 16: number of matched writes.
- err_chan out 2: channel of the first error.
- err_obs out 32: observed data of the first error.
- err_exp out 32: expected data of the first error (0 if the FIFO was empty).

Function
REQ-003 States: IDLE, RUN, PASS, FAIL, TOUT; PASS, FAIL and TOUT are terminal until rst.
REQ-004 A load happens when exp_valid && exp_ready on a clock edge; exp_data is pushed into the FIFO of exp_chan; exp_last sets a sticky last_seen flag.
REQ-005 IDLE->RUN on start; start is ignored in every other state.
REQ-006 A write hits channel k when iobus_wr is high and iobus_addr == BASE_ADDR + k*ADDR_STRIDE; hits are sampled only in RUN; all other writes are ignored.
REQ-007 Hit on a non-empty FIFO with a match: pop the head, increment pass_count, stay in RUN.
REQ-008 Hit on a non-empty FIFO with a mismatch: go to FAIL; capture err_chan, err_obs, err_exp; the FIFO is not popped.
REQ-009 Hit on an empty FIFO: go to FAIL; err_exp=0.
REQ-010 In RUN, with last_seen set and all FIFOs empty after the edge's updates: go to PASS on the following edge.
REQ-011 The cycle counter increments every RUN cycle; reaching TIMEOUT_CYCLES with no other transition goes to TOUT.
REQ-012 Priority in one cycle: FAIL > PASS > TOUT.
REQ-013 A load and a pop on the same channel in the same cycle are both performed; the FIFO counts as not full if a pop occurs that cycle (full-FIFO push-through is allowed).
REQ-014 Latency: status outputs reflect a write one cycle after the edge on which it is sampled.
REQ-015 done = pass | fail | timeout; exactly one of the three is high in a terminal state.
REQ-016 pass_count saturates at 16'hFFFF.
REQ-017 exp_ready is low in terminal states.
REQ-018 FIFO pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.

Reset
REQ-019 rst, when sampled high, takes precedence over all other inputs.
REQ-020 rst forces the following: state=IDLE; all FIFOs empty; last_seen=0; cycle counter=0; pass_count=0; done/pass/fail/timeout=0; err_chan, err_obs, err_exp=0.
REQ-021 rst asserted mid-RUN discards all pending expected values.

Configuration
REQ-022 Macro IOCHK_MASK_EN:
- Defined: adds input exp_mask[31:0], stored with each FIFO entry; a match is ((iobus_out ^ exp) & mask)==0.
- Undefined: the port and its storage are absent; a match requires full 32-bit equality.

Verification
REQ-023 NUM_CH=1: load 10, 30, 83886080 (last); start; CPU writes the same values to 32'hFFFF0000 -> pass=1 one cycle after the third write, pass_count=3.
REQ-024 Load 10 (last); start; write 11 -> fail=1, err_chan=0, err_obs=11, err_exp=10, pass_count=0.
REQ-025 NUM_CH=2: load ch1=5 (last); start; write 7 to 32'hFFFF0004 before any load on ch0, then write 5 to ch0 -> fail on the first write; err_chan=1.
- Correction: ch0 is empty, so the first write is the ch1 write of 7; the expected result is fail, err_chan=1, err_obs=7, err_exp=5.
REQ-026 TIMEOUT_CYCLES=50: load 1 (last); start; no writes -> timeout=1 exactly 50 cycles after start; pass=fail=0.
REQ-027 DEPTH=2: fill ch0; hold exp_valid while a matching write pops in the same cycle -> push accepted, no data lost; then assert rst mid-RUN -> all outputs return to their reset values next cycle.
REQ-028 IOCHK_MASK_EN defined: exp=32'hFFFFFFE2, mask=32'h000000FF; write 32'h123456E2 -> match, pass_count=1.
